// File: rtl/yarp_pkg.sv
// Shared types for the yarp instruction-fetch slice: FSM states, NOP encoding
// and the {pc, instr} entry carried through the fetch buffer.
package yarp_pkg;

   typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_DISCARD} fetch_state_e;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/yarp_fetch_fifo.sv
// DEPTH-entry buffer of fetched {pc, instr}; head visible combinationally, zero-cycle read.
// Push when full is dropped unless a pop frees the slot; flush wins over push and pop.
module yarp_fetch_fifo
   import yarp_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_entry_t           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_MAX);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/yarp_instr_fetch.sv
// Instruction fetch: one outstanding imem read, results buffered for decode; redirect -> req next cycle.
// Decode holds the head with stall_i; no request is issued unless a buffer slot is reserved for it.
module yarp_instr_fetch
   import yarp_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_M1 = CW'(FIFO_DEPTH - 1);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          outstanding;
   logic          room;
   logic          b2b_room;
   logic          pop;
   logic          push;
   fetch_entry_t  push_data;
   fetch_entry_t  head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] count;

   assign outstanding = (state_q == F_WAIT) || (state_q == F_DISCARD);
   assign room        = (count + CW'(outstanding)) < DEPTH_C;
   assign pop         = instr_valid_o && !stall_i;
   // Slot check for issuing the next request in the same cycle the current one returns.
   assign b2b_room    = pop ? !fifo_full : (count < DEPTH_M1);
   assign push_data   = '{pc: fetch_pc_q - 32'd4, instr: imem_rdata_i};

   yarp_fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_i),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= F_IDLE;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      imem_req_o = 1'b0;
      push       = 1'b0;
      case (state_q)
         F_IDLE: begin
            if (redirect_i || room) state_d = F_REQ;
         end
         F_REQ: begin
            imem_req_o = 1'b1;
            if (imem_gnt_i) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = F_WAIT;
            end
            if (redirect_i) state_d = imem_gnt_i ? F_DISCARD : F_REQ;
         end
         F_WAIT: begin
            if (imem_rvalid_i) begin
               if (redirect_i) begin
                  state_d = F_REQ;
               end else begin
                  push = 1'b1;
                  if (b2b_room) begin
                     imem_req_o = 1'b1;
                     if (imem_gnt_i) fetch_pc_d = fetch_pc_q + 32'd4;
                     else            state_d    = F_REQ;
                  end else begin
                     state_d = F_IDLE;
                  end
               end
            end else if (redirect_i) begin
               state_d = F_DISCARD;
            end
         end
         F_DISCARD: begin
            if (imem_rvalid_i) state_d = F_REQ;
         end
         default: state_d = F_IDLE;
      endcase
      if (redirect_i) fetch_pc_d = word_align(redirect_pc_i);
   end

   assign imem_addr_o   = fetch_pc_q;
   assign instr_valid_o = !fifo_empty;
   assign instr_o       = instr_valid_o ? head.instr : INSTR_NOP;
   assign pc_o          = instr_valid_o ? head.pc : 32'd0;

endmodule

// File: tb/tb_yarp_instr_fetch.sv
// Bench for yarp_instr_fetch: memory model + expected-stream scoreboard, directed and random phases.
module tb_yarp_instr_fetch;
   import yarp_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'd0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'd0;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;

   always #5 clk = ~clk;

   yarp_instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o)
   );

   int           n_cmp = 0;
   int           n_err = 0;
   int           n_consumed = 0;
   fetch_entry_t exp_q [$];
   logic [31:0]  exp_tail;
   logic [31:0]  exp_req_pc;
   logic         pend = 1'b0;
   logic [31:0]  pend_addr;
   int           pend_cnt = 0;
   int           rsp_lat = 1;
   logic         prev_redir = 1'b0;
   fetch_entry_t mon_e;

   // Instruction memory contents: word i holds the value i.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr >> 2;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 16) begin
         exp_q.push_back('{pc: exp_tail, instr: mem_word(exp_tail)});
         exp_tail = exp_tail + 32'd4;
      end
   endtask

   task automatic restart_stream(input logic [31:0] target);
      exp_q.delete();
      exp_tail = {target[31:2], 2'b00};
      refill();
   endtask

   // One clock of stimulus; returns 2 time units after the driving negedge.
   task automatic cycle(input logic stall, input logic gnt, input logic redir, input logic [31:0] rpc);
      logic delivered;
      @(negedge clk);
      delivered     = pend && (pend_cnt == 0);
      stall_i       = stall;
      imem_gnt_i    = gnt;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      imem_rvalid_i = delivered;
      imem_rdata_i  = delivered ? mem_word(pend_addr) : $urandom();
      if (redir) restart_stream(rpc);
      #2;
      if (delivered) pend = 1'b0;
      else if (pend) pend_cnt--;
      if (imem_req_o && gnt) begin
         chk("single_outstanding", {31'd0, pend}, 32'd0);
         chk("req_addr", imem_addr_o, exp_req_pc);
         pend       = 1'b1;
         pend_addr  = imem_addr_o;
         pend_cnt   = rsp_lat - 1;
         exp_req_pc = exp_req_pc + 32'd4;
      end
      if (redir) exp_req_pc = {rpc[31:2], 2'b00};
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      #1;
      chk("rst_req", {31'd0, imem_req_o}, 32'd0);
      chk("rst_addr", imem_addr_o, RESET_PC);
      chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
      chk("rst_instr", instr_o, INSTR_NOP);
      chk("rst_pc", pc_o, 32'd0);
      pend          = 1'b0;
      rsp_lat       = 1;
      exp_req_pc    = RESET_PC;
      restart_stream(RESET_PC);
      stall_i       = 1'b0;
      imem_gnt_i    = 1'b0;
      redirect_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: every consumed head must be the next word of the current program stream.
   always @(negedge clk) begin
      #3;
      if (reset) begin
         prev_redir = 1'b0;
      end else begin
         if (prev_redir) chk("flush_after_redirect", {31'd0, instr_valid_o}, 32'd0);
         if (!instr_valid_o) begin
            chk("nop_when_invalid", instr_o, INSTR_NOP);
            chk("pc_zero_when_invalid", pc_o, 32'd0);
         end else if (!stall_i && !redirect_i) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL stream_underflow: got pc %h with nothing expected", pc_o);
            end else begin
               mon_e = exp_q.pop_front();
               chk("pc_o", pc_o, mon_e.pc);
               chk("instr_o", instr_o, mon_e.instr);
               n_consumed++;
               refill();
            end
         end
         prev_redir = redirect_i;
      end
   end

   initial begin
      int first_valid;
      int base;
      logic found;
      logic [31:0] tgt;

      #1;
      reset_dut();

      // Zero-wait memory, no stall: first valid on cycle 3, then one per cycle.
      first_valid = 0;
      base = n_consumed;
      for (int c = 1; c <= 10; c++) begin
         cycle(1'b0, 1'b1, 1'b0, 32'd0);
         if (instr_valid_o && first_valid == 0) first_valid = c;
      end
      #2;
      chk("first_valid_cycle", 32'(first_valid), 32'd3);
      chk("stream_rate", 32'(n_consumed - base), 32'd8);

      // Stall after the first valid: buffer fills, requests stop, head frozen.
      reset_dut();
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      base = n_consumed;
      for (int c = 0; c < 5; c++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'd0);
         chk("stall_req", {31'd0, imem_req_o}, 32'd0);
         chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
         chk("stall_pc", pc_o, 32'd0);
         chk("stall_instr", instr_o, 32'd0);
      end
      #2;
      chk("stall_no_consume", 32'(n_consumed - base), 32'd0);
      base = n_consumed;
      repeat (8) cycle(1'b0, 1'b1, 1'b0, 32'd0);
      #2;
      chk("resume_count", 32'(n_consumed - base), 32'd6);

      // Grant withheld for 3 cycles on the second request.
      reset_dut();
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      for (int c = 0; c < 3; c++) begin
         cycle(1'b0, 1'b0, 1'b0, 32'd0);
         chk("gnt_wait_req", {31'd0, imem_req_o}, 32'd1);
         chk("gnt_wait_addr", imem_addr_o, 32'h4);
      end
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("gnt_final_addr", imem_addr_o, 32'h4);
      repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'd0);

      // Redirect during WAIT with a late response.
      reset_dut();
      rsp_lat = 3;
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      rsp_lat = 1;
      cycle(1'b0, 1'b1, 1'b1, 32'h100);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("discard_req_a", {31'd0, imem_req_o}, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("discard_req_b", {31'd0, imem_req_o}, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("redir_req", {31'd0, imem_req_o}, 32'd1);
      chk("redir_addr", imem_addr_o, 32'h100);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         cycle(1'b0, 1'b1, 1'b0, 32'd0);
         if (instr_valid_o) begin
            chk("first_pc_after_redirect", pc_o, 32'h100);
            found = 1'b1;
         end
      end
      if (!found) chk("redirect_valid_timeout", 32'd0, 32'd1);

      // Redirect to unaligned target together with gnt and pop.
      reset_dut();
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 1'b1, 32'h203);
      chk("pop_pending_at_redirect", {31'd0, instr_valid_o}, 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("fifo_flushed", {31'd0, instr_valid_o}, 32'd0);
      chk("stale_no_req", {31'd0, imem_req_o}, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      chk("refetch_req", {31'd0, imem_req_o}, 32'd1);
      chk("refetch_addr", imem_addr_o, 32'h200);
      repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'd0);

      // Reset asserted mid-WAIT with the buffer fully committed.
      reset_dut();
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      rsp_lat = 3;
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      chk("full_before_reset", {31'd0, instr_valid_o}, 32'd1);
      chk("full_no_req", {31'd0, imem_req_o}, 32'd0);
      reset_dut();
      found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
         cycle(1'b0, 1'b1, 1'b0, 32'd0);
         if (imem_req_o) begin
            chk("first_req_after_reset", imem_addr_o, RESET_PC);
            found = 1'b1;
         end
      end
      if (!found) chk("req_after_reset_timeout", 32'd0, 32'd1);
      repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'd0);

      // Random traffic, including redirects near the top of the address space.
      base = n_consumed;
      for (int i = 0; i < 3000; i++) begin
         rsp_lat = $urandom_range(1, 3);
         tgt = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, tgt);
      end
      #2;
      chk("random_progress", {31'd0, (n_consumed - base) > 100}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
